// File: rtl/car_traffic_controller_if.sv
// Bundles the control inputs and the lane/level/moving outputs of the traffic
// controller. The player/score logic is the master; the controller is the slave.
interface car_traffic_controller_if;
    logic       LEVEL_UP;
    logic       HIT;
    logic       PAUSE;
    logic [9:0] car_x1;
    logic [9:0] car_x2;
    logic [9:0] car_x3;
    logic [9:0] car_x4;
    logic [9:0] car_x5;
    logic [9:0] car_x6;
    logic [3:0] level;
    logic       moving;

    modport master (
        output LEVEL_UP,
        output HIT,
        output PAUSE,
        input  car_x1,
        input  car_x2,
        input  car_x3,
        input  car_x4,
        input  car_x5,
        input  car_x6,
        input  level,
        input  moving
    );

    modport slave (
        input  LEVEL_UP,
        input  HIT,
        input  PAUSE,
        output car_x1,
        output car_x2,
        output car_x3,
        output car_x4,
        output car_x5,
        output car_x6,
        output level,
        output moving
    );
endinterface

// File: rtl/car_traffic_controller.sv
// Six-lane car position generator. Odd lanes scroll right by STEP, even lanes
// scroll left by 2*STEP, all wrapping modulo H_DISPLAY. A tick counter paces the
// stepping; its period shrinks with the level. A hit freezes traffic for
// HOLD_CYCLES, and PAUSE freezes everything until released.
module car_traffic_controller #(
    parameter int H_DISPLAY    = 640,
    parameter int STEP         = 1,
    parameter int BASE_PERIOD  = 400000,
    parameter int PERIOD_DEC   = 30000,
    parameter int MIN_PERIOD   = 100000,
    parameter int MAX_LEVEL    = 9,
    parameter int HOLD_CYCLES  = 25000000,
    parameter int LANE_SPACING = 96
) (
    input  logic                       CLK,
    input  logic                       RST,
    car_traffic_controller_if.slave    bus
);

    // Fixed-width views of the parameters so every compare is width-matched.
    localparam logic [10:0] H_W      = 11'(H_DISPLAY);
    localparam logic [10:0] D_RIGHT  = 11'(STEP);
    localparam logic [10:0] D_LEFT   = 11'(2 * STEP);
    localparam logic [31:0] BASE_W   = 32'(BASE_PERIOD);
    localparam logic [31:0] DEC_W    = 32'(PERIOD_DEC);
    localparam logic [31:0] MIN_W    = 32'(MIN_PERIOD);
    localparam logic [31:0] HOLD_W   = 32'(HOLD_CYCLES);
    localparam logic [3:0]  MAX_LV   = 4'(MAX_LEVEL);
    localparam int          NUM_LANES = 6;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HOLD   = 2'd1,
        ST_PAUSED = 2'd2
    } state_t;

    // Rightward step with wrap; the 11-bit sum cannot overflow for x < H_DISPLAY.
    function automatic logic [9:0] step_right(input logic [9:0] x, input logic [10:0] d);
        logic [10:0] sum;
        logic [10:0] res;
        sum = {1'b0, x} + d;
        if (sum >= H_W) begin
            res = sum - H_W;
        end else begin
            res = sum;
        end
        return res[9:0];
    endfunction

    // Leftward step with wrap; borrow from H_DISPLAY when the lane would go negative.
    function automatic logic [9:0] step_left(input logic [9:0] x, input logic [10:0] d);
        logic [10:0] res;
        if ({1'b0, x} < d) begin
            res = {1'b0, x} + H_W - d;
        end else begin
            res = {1'b0, x} - d;
        end
        return res[9:0];
    endfunction

    state_t      state_q,  state_d;
    logic [31:0] tick_q,   tick_d;
    logic [31:0] hold_q,   hold_d;
    logic [3:0]  level_q,  level_d;
    logic        moving_q, moving_d;
    logic [9:0]  car_x_q [NUM_LANES];
    logic [9:0]  car_x_d [NUM_LANES];

    logic [31:0] dec_total_s;
    logic [31:0] period_raw_s;
    logic [31:0] eff_period_s;
    logic        step_s;

    // Effective tick period from the registered level, floored at MIN_PERIOD and
    // guarded against unsigned underflow when the decrement exceeds the base.
    always_comb begin
        dec_total_s  = 32'({28'd0, level_q}) * DEC_W;
        period_raw_s = 32'd0;
        eff_period_s = MIN_W;
        if (dec_total_s >= BASE_W) begin
            eff_period_s = MIN_W;
        end else begin
            period_raw_s = BASE_W - dec_total_s;
            if (period_raw_s < MIN_W) begin
                eff_period_s = MIN_W;
            end else begin
                eff_period_s = period_raw_s;
            end
        end
    end

    // Next-state logic: FSM transitions, counters, level and lane stepping.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        hold_d  = hold_q;
        level_d = level_q;
        step_s  = 1'b0;
        for (int k = 0; k < NUM_LANES; k++) begin
            car_x_d[k] = car_x_q[k];
        end

        // Level advances in any state and saturates.
        if (bus.LEVEL_UP) begin
            if (level_q >= MAX_LV) begin
                level_d = MAX_LV;
            end else begin
                level_d = level_q + 4'd1;
            end
        end else begin
            level_d = level_q;
        end

        case (state_q)
            ST_RUN: begin
                if (bus.PAUSE) begin
                    state_d = ST_PAUSED;
                end else if (bus.HIT) begin
                    state_d = ST_HOLD;
                    hold_d  = 32'd0;
                end else begin
                    state_d = ST_RUN;
                    if (tick_q >= eff_period_s - 32'd1) begin
                        tick_d = 32'd0;
                        step_s = 1'b1;
                    end else begin
                        tick_d = tick_q + 32'd1;
                    end
                end
            end
            ST_HOLD: begin
                if (bus.PAUSE) begin
                    state_d = ST_PAUSED;
                end else if (bus.HIT) begin
                    state_d = ST_HOLD;
                    hold_d  = 32'd0;
                end else if (hold_q >= HOLD_W - 32'd1) begin
                    state_d = ST_RUN;
                    hold_d  = 32'd0;
                end else begin
                    state_d = ST_HOLD;
                    hold_d  = hold_q + 32'd1;
                end
            end
            ST_PAUSED: begin
                if (bus.PAUSE) begin
                    state_d = ST_PAUSED;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        // Lane index 0,2,4 are cars 1,3,5 (rightward); 1,3,5 are cars 2,4,6 (leftward).
        if (step_s) begin
            for (int k = 0; k < NUM_LANES; k++) begin
                if ((k % 2) == 0) begin
                    car_x_d[k] = step_right(car_x_q[k], D_RIGHT);
                end else begin
                    car_x_d[k] = step_left(car_x_q[k], D_LEFT);
                end
            end
        end else begin
            for (int k = 0; k < NUM_LANES; k++) begin
                car_x_d[k] = car_x_q[k];
            end
        end

        moving_d = (state_d == ST_RUN);
    end

    // All state, counters and outputs registered; RST wins over every input.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_RUN;
            tick_q   <= 32'd0;
            hold_q   <= 32'd0;
            level_q  <= 4'd0;
            moving_q <= 1'b1;
            for (int k = 0; k < NUM_LANES; k++) begin
                car_x_q[k] <= 10'(k * LANE_SPACING);
            end
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            hold_q   <= hold_d;
            level_q  <= level_d;
            moving_q <= moving_d;
            for (int k = 0; k < NUM_LANES; k++) begin
                car_x_q[k] <= car_x_d[k];
            end
        end
    end

    assign bus.car_x1 = car_x_q[0];
    assign bus.car_x2 = car_x_q[1];
    assign bus.car_x3 = car_x_q[2];
    assign bus.car_x4 = car_x_q[3];
    assign bus.car_x5 = car_x_q[4];
    assign bus.car_x6 = car_x_q[5];
    assign bus.level  = level_q;
    assign bus.moving = moving_q;

endmodule

// File: tb/tb_car_traffic_controller.sv
// Directed bench for car_traffic_controller with a cycle-level reference model.
// Each cycle the model's expected outputs are queued when inputs are driven and
// popped for comparison after the clock edge; directed checks pin the values
// from the test plan.
module tb_car_traffic_controller;

    localparam int P_H    = 640;
    localparam int P_BASE = 4;
    localparam int P_DEC  = 1;
    localparam int P_MIN  = 2;
    localparam int P_MAXL = 9;
    localparam int P_HOLD = 8;
    localparam int P_SPC  = 96;

    logic CLK;
    logic RST;
    car_traffic_controller_if ifc ();

    car_traffic_controller #(
        .H_DISPLAY    (P_H),
        .STEP         (1),
        .BASE_PERIOD  (P_BASE),
        .PERIOD_DEC   (P_DEC),
        .MIN_PERIOD   (P_MIN),
        .MAX_LEVEL    (P_MAXL),
        .HOLD_CYCLES  (P_HOLD),
        .LANE_SPACING (P_SPC)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (ifc)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;

    // Reference model state: 0 = RUN, 1 = HOLD, 2 = PAUSED.
    int m_state, m_tick, m_hold, m_level;
    int m_x [6];
    bit m_moving;

    logic [64:0] exp_q [$];

    function automatic logic [64:0] model_pack();
        return {10'(m_x[0]), 10'(m_x[1]), 10'(m_x[2]), 10'(m_x[3]), 10'(m_x[4]), 10'(m_x[5]),
                4'(m_level), m_moving};
    endfunction

    function automatic logic [64:0] dut_pack();
        return {ifc.car_x1, ifc.car_x2, ifc.car_x3, ifc.car_x4, ifc.car_x5, ifc.car_x6,
                ifc.level, ifc.moving};
    endfunction

    task automatic model_update(input bit rst, input bit lu, input bit hit, input bit pau);
        int p;
        if (rst) begin
            for (int k = 0; k < 6; k++) m_x[k] = k * P_SPC;
            m_level = 0; m_state = 0; m_tick = 0; m_hold = 0; m_moving = 1'b1;
        end else begin
            p = P_BASE - m_level * P_DEC;
            if (p < P_MIN) p = P_MIN;
            if (lu && m_level < P_MAXL) m_level = m_level + 1;
            if (m_state == 0) begin
                if (pau) m_state = 2;
                else if (hit) begin m_state = 1; m_hold = 0; end
                else if (m_tick + 1 >= p) begin
                    m_tick = 0;
                    for (int k = 0; k < 6; k++) begin
                        if (k % 2 == 0) m_x[k] = (m_x[k] + 1) % P_H;
                        else            m_x[k] = (m_x[k] + P_H - 2) % P_H;
                    end
                end else m_tick = m_tick + 1;
            end else if (m_state == 1) begin
                if (pau) m_state = 2;
                else if (hit) m_hold = 0;
                else if (m_hold == P_HOLD - 1) begin m_state = 0; m_hold = 0; end
                else m_hold = m_hold + 1;
            end else begin
                if (!pau) m_state = 0;
            end
            m_moving = (m_state == 0);
        end
    endtask

    // One clock cycle: drive inputs, queue expectation, compare after the edge.
    task automatic cyc(input bit rst, input bit lu, input bit hit, input bit pau);
        logic [64:0] got;
        logic [64:0] expv;
        @(negedge CLK);
        RST = rst; ifc.LEVEL_UP = lu; ifc.HIT = hit; ifc.PAUSE = pau;
        model_update(rst, lu, hit, pau);
        exp_q.push_back(model_pack());
        @(posedge CLK);
        #1;
        cyc_n++;
        got  = dut_pack();
        expv = exp_q.pop_front();
        checks++;
        assert (got === expv)
        else begin
            errors++;
            $error("FAIL scoreboard cycle=%0d observed=%h expected=%h", cyc_n, got, expv);
        end
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    initial begin
        int s1, s2, s4, prev, n;
        RST = 1'b1; ifc.LEVEL_UP = 1'b0; ifc.HIT = 1'b0; ifc.PAUSE = 1'b0;

        // Reset values
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        check("rst_x1", int'(ifc.car_x1), 0);
        check("rst_x2", int'(ifc.car_x2), 96);
        check("rst_x3", int'(ifc.car_x3), 192);
        check("rst_x4", int'(ifc.car_x4), 288);
        check("rst_x5", int'(ifc.car_x5), 384);
        check("rst_x6", int'(ifc.car_x6), 480);
        check("rst_level", int'(ifc.level), 0);
        check("rst_moving", int'(ifc.moving), 1);

        // Twelve cycles at period 4 give three steps
        repeat (12) idle();
        check("run_x1", int'(ifc.car_x1), 3);
        check("run_x2", int'(ifc.car_x2), 90);
        check("run_x3", int'(ifc.car_x3), 195);
        check("run_x4", int'(ifc.car_x4), 282);
        check("run_x5", int'(ifc.car_x5), 387);
        check("run_x6", int'(ifc.car_x6), 474);

        // Hit hold: frozen for eight cycles then resumes
        s1 = int'(ifc.car_x1); s2 = int'(ifc.car_x2);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        check("hold_moving0", int'(ifc.moving), 0);
        repeat (7) idle();
        check("hold_moving7", int'(ifc.moving), 0);
        check("hold_x1_frozen", int'(ifc.car_x1), s1);
        check("hold_x2_frozen", int'(ifc.car_x2), s2);
        idle();
        check("hold_release_moving", int'(ifc.moving), 1);
        check("hold_release_x1", int'(ifc.car_x1), s1);
        n = 0;
        while (int'(ifc.car_x1) == s1 && n < 10) begin idle(); n++; end
        check("hold_resume_cycles", n, 4);

        // Re-hit during hold restarts the eight-cycle freeze
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (5) idle();
        s1 = int'(ifc.car_x1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (7) idle();
        check("rehit_moving", int'(ifc.moving), 0);
        check("rehit_x1", int'(ifc.car_x1), s1);
        idle();
        check("rehit_release", int'(ifc.moving), 1);

        // Pause beats hit; release returns straight to RUN with positions kept
        repeat (2) idle();
        s1 = int'(ifc.car_x1); s4 = int'(ifc.car_x4);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        check("pause_moving", int'(ifc.moving), 0);
        repeat (4) cyc(1'b0, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("pause_release_moving", int'(ifc.moving), 1);
        check("pause_x1_kept", int'(ifc.car_x1), s1);
        check("pause_x4_kept", int'(ifc.car_x4), s4);

        // Pause abandons an in-progress hold
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (2) idle();
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        idle();
        check("pause_abandons_hold", int'(ifc.moving), 1);

        // Level saturation and the minimum period
        repeat (12) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b0);
            idle();
        end
        check("level_sat", int'(ifc.level), 9);
        prev = int'(ifc.car_x1); n = 0;
        while (int'(ifc.car_x1) == prev && n < 10) begin idle(); n++; end
        check("level_step_seen", int'(n < 10), 1);
        prev = int'(ifc.car_x1); n = 0;
        while (int'(ifc.car_x1) == prev && n < 10) begin idle(); n++; end
        check("min_period", n, 2);

        // Lane 1 wrap 639 -> 0
        n = 0;
        while (int'(ifc.car_x1) != 639 && n < 2000) begin idle(); n++; end
        check("x1_reach_639", int'(ifc.car_x1), 639);
        n = 0;
        while (int'(ifc.car_x1) == 639 && n < 4) begin idle(); n++; end
        check("x1_wrap", int'(ifc.car_x1), 0);

        // Lane 2 wrap 0 -> 638
        n = 0;
        while (int'(ifc.car_x2) != 0 && n < 2000) begin idle(); n++; end
        check("x2_reach_0", int'(ifc.car_x2), 0);
        n = 0;
        while (int'(ifc.car_x2) == 0 && n < 4) begin idle(); n++; end
        check("x2_wrap", int'(ifc.car_x2), 638);

        // Reset mid-hold with LEVEL_UP in the same cycle
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (2) idle();
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        check("rst2_x1", int'(ifc.car_x1), 0);
        check("rst2_x6", int'(ifc.car_x6), 480);
        check("rst2_level", int'(ifc.level), 0);
        check("rst2_moving", int'(ifc.moving), 1);
        repeat (6) idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/car_traffic_controller.md
Name: car_traffic_controller

Overview:
- Generates horizontal positions of the six lane cars consumed by the player/collision logic (car_x1..car_x6) and by the VGA renderer.
- Cars scroll continuously with modular wrap-around. Odd lanes move right, even lanes move left.
- Speed rises with a level counter advanced by a score pulse. Traffic briefly halts after a player hit and freezes while paused.

Parameters:
- H_DISPLAY, 640: horizontal wrap modulus in pixels.
- STEP, 1: pixels moved per tick by odd lanes. Even lanes move 2*STEP.
- BASE_PERIOD, 400000: CLK cycles per tick at level 0.
- PERIOD_DEC, 30000: cycles removed from the period per level.
- MIN_PERIOD, 100000: floor on the tick period.
- MAX_LEVEL, 9: saturation value of the level.
- HOLD_CYCLES, 25000000: length of the post-hit freeze in cycles.
- LANE_SPACING, 96: initial x offset between consecutive lanes.

Ports:
- CLK, in, 1: system clock.
- RST, in, 1: synchronous active-high reset.
- LEVEL_UP, in, 1: one-cycle pulse, player scored.
- HIT, in, 1: one-cycle pulse, player collided with a car.
- PAUSE, in, 1: level; freezes traffic while high.
- car_x1..car_x6, out, 10 each: car left-edge x positions.
- level, out, 4: current level, 0..MAX_LEVEL.
- moving, out, 1: high only in the RUN state.

Behaviour:
- Reset, sampled on posedge CLK while RST=1:
  - car_xk = (k-1)*LANE_SPACING, i.e. 0, 96, 192, 288, 384, 480.
  - level=0, state=RUN, moving=1.
  - Tick counter=0, hold counter=0.
  - RST overrides every other input in the same cycle.
- Period: eff_period = max(BASE_PERIOD - level*PERIOD_DEC, MIN_PERIOD), computed in 32-bit unsigned arithmetic.
  - Combinational from registered level.
  - A level change takes effect on the next counter compare; the tick counter is not reset.
- State RUN:
  - Tick counter increments each cycle.
  - When counter >= eff_period-1: counter <= 0, all six lanes step that same cycle.
  - First step occurs eff_period cycles after reset release.
- Lane step, with d = STEP for odd k and 2*STEP for even k:
  - Odd k (rightward): x <= (x + d >= H_DISPLAY) ? x + d - H_DISPLAY : x + d.
  - Even k (leftward): x <= (x < d) ? x + H_DISPLAY - d : x - d.
  - Outputs always stay within 0..H_DISPLAY-1. Intermediate sums use 11 bits.
- State HOLD:
  - Entered from RUN on HIT=1 (and PAUSE=0); hold counter <= 0.
  - Positions and tick counter frozen; hold counter increments.
  - When hold counter = HOLD_CYCLES-1: go to RUN.
  - HIT during HOLD restarts the hold counter at 0.
- State PAUSED:
  - Entered from RUN or HOLD whenever PAUSE=1. PAUSE has priority over HIT.
  - Positions, tick counter and hold counter frozen; HIT ignored.
  - On PAUSE=0: return to RUN. An interrupted hold is abandoned.
- Level:
  - LEVEL_UP=1 in any state: level <= min(level+1, MAX_LEVEL). Saturates, never wraps.
  - LEVEL_UP and HIT in the same cycle: both take effect.
- moving is registered and equals (next state == RUN).
- Out-of-range internal state encoding: return to RUN.

Test Plan:
Parameters for all tests: BASE_PERIOD=4, PERIOD_DEC=1, MIN_PERIOD=2, HOLD_CYCLES=8, STEP=1.
1. Reset, then run 12 cycles.
   - Each lane is stepped 3 times.
   - Expect car_x1=3, car_x2=90, car_x3=195, car_x4=282, car_x5=387, car_x6=474.
2. Wrap-around.
   - Force car_x1=639 via reset-released sequence; one tick → car_x1=0.
   - Lane 2 at 1 after 1 tick → 639.
3. Level saturation.
   - Pulse LEVEL_UP 12 times → level=9.
   - Tick period measured as 2 cycles (the MIN_PERIOD floor).
4. Hit hold.
   - HIT in RUN → moving=0, positions unchanged for 8 cycles, then moving=1 and stepping resumes.
   - Second HIT at hold cycle 5 → 8 more cycles frozen.
5. Pause priority.
   - PAUSE=1 and HIT=1 together → PAUSED, no hold.
   - After PAUSE=0 → RUN immediately; positions identical to pre-pause values.
6. Reset mid-HOLD with LEVEL_UP asserted the same cycle → all reset values, level=0.
